// File: rtl/design_08_issuer.sv
// -----------------------------------------------------------------------------
// design_08_issuer
//   Initiator for the design_08 start/valid datapath. Operand pairs arrive on an
//   upstream valid/ready stream and are buffered in a small FIFO. One pair at a
//   time is popped, presented on dut_a/dut_b with a one-cycle dut_start pulse,
//   and the issuer then waits for dut_valid with a bounded timeout. The result
//   (or a timeout error) is held on a downstream valid/ready stream until taken.
//
// Parameters
//   W        operand/result width (must match design_08)
//   DEPTH    operand FIFO entries (power of 2, >= 2)
//   TIMEOUT  WAIT cycles allowed before an error completion (1..255)
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        upstream handshake; in_ready = FIFO not full
//   in_a, in_b               upstream operand pair
//   dut_start                one-cycle start pulse to design_08
//   dut_a, dut_b             operands to design_08, stable between pops
//   dut_y, dut_valid         result and result-valid from design_08
//   out_valid/out_ready      downstream handshake
//   out_y                    captured result (0 on timeout)
//   out_err                  1 = transaction timed out
//   busy                     FSM not idle or FIFO non-empty
//
// Optional feature (macro DESIGN_08_ISSUER_STATS_EN)
//   Adds stat_done[15:0] and stat_tmo[15:0]: saturating counts of normal and
//   timed-out results accepted downstream.
// -----------------------------------------------------------------------------
module design_08_issuer #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         dut_start,
  output logic [W-1:0] dut_a,
  output logic [W-1:0] dut_b,
  input  logic [W-1:0] dut_y,
  input  logic         dut_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_err,
  output logic         busy
`ifdef DESIGN_08_ISSUER_STATS_EN
  ,
  output logic [15:0]  stat_done,
  output logic [15:0]  stat_tmo
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [W-1:0]     dut_a_q, dut_a_d;
  logic [W-1:0]     dut_b_q, dut_b_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_y_q, out_y_d;
  logic             out_err_q, out_err_d;

  // Operand storage; not reset, read only when count says the entry is live.
  logic [2*W-1:0]   mem [DEPTH];

  logic push, pop;

  // in_ready comes straight from the registered count, so a pop in the same
  // cycle does not reopen a full FIFO until the next cycle.
  assign in_ready  = (count_q != (AW+1)'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  assign dut_start = (state_q == S_ISSUE);
  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_err   = out_err_q;
  assign busy      = (state_q != S_IDLE) || (count_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          dut_a_d = mem[rd_ptr_q][2*W-1:W];
          dut_b_d = mem[rd_ptr_q][W-1:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A result arriving on the last allowed cycle still counts as normal.
        if (dut_valid) begin
          out_y_d     = dut_y;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          out_y_d     = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dut_a_q     <= '0;
      dut_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_err_q   <= out_err_d;
    end
  end

`ifdef DESIGN_08_ISSUER_STATS_EN
  logic [15:0] stat_done_q, stat_done_d;
  logic [15:0] stat_tmo_q, stat_tmo_d;
  logic        accept;

  assign accept    = out_valid_q && out_ready;
  assign stat_done = stat_done_q;
  assign stat_tmo  = stat_tmo_q;

  always_comb begin
    stat_done_d = stat_done_q;
    stat_tmo_d  = stat_tmo_q;
    if (accept && !out_err_q && (stat_done_q != 16'hFFFF)) begin
      stat_done_d = stat_done_q + 16'd1;
    end
    if (accept && out_err_q && (stat_tmo_q != 16'hFFFF)) begin
      stat_tmo_d = stat_tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done_q <= '0;
      stat_tmo_q  <= '0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_tmo_q  <= stat_tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_design_08_issuer.sv
// -----------------------------------------------------------------------------
// tb_design_08_issuer
//   Directed bench for design_08_issuer. A small responder stands in for
//   design_08 (y = a + b after a programmable delay, or never). Expected
//   results are queued when operands are pushed and compared when the issuer
//   hands a result downstream.
// -----------------------------------------------------------------------------
module tb_design_08_issuer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, dut_start, dut_valid;
  logic        out_valid, out_ready, out_err, busy;
  logic [15:0] in_a, in_b, dut_a, dut_b, dut_y, out_y;
`ifdef DESIGN_08_ISSUER_STATS_EN
  logic [15:0] stat_done, stat_tmo;
`endif

  // Responder output and stray pulses injected by the stimulus are merged.
  logic        resp_valid = 1'b0;
  logic        junk_valid = 1'b0;
  logic [15:0] resp_y = '0;
  logic [15:0] junk_y = '0;
  logic [15:0] resp_calc;
  assign dut_valid = resp_valid | junk_valid;
  assign dut_y     = resp_valid ? resp_y : junk_y;

  design_08_issuer #(.W(16), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .dut_start (dut_start),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_y     (dut_y),
    .dut_valid (dut_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err),
    .busy      (busy)
`ifdef DESIGN_08_ISSUER_STATS_EN
    ,
    .stat_done (stat_done),
    .stat_tmo  (stat_tmo)
`endif
  );

  typedef struct packed {
    logic        err;
    logic [15:0] y;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pops = 0;
  int   n_starts = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = 0;
  int   push_cyc = 0;
  int   push_wait = 0;
  bit   resp_en = 1'b1;
  int   resp_delay = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // design_08 stand-in: result y = a + b, dut_valid in the cycle that is
  // resp_delay cycles after the dut_start cycle.
  always begin
    @(negedge clk);
    if (dut_start && resp_en && !rst) begin
      resp_calc = dut_a + dut_b;
      repeat (resp_delay) @(posedge clk);
      #1;
      resp_valid = 1'b1;
      resp_y     = resp_calc;
      @(posedge clk);
      #1;
      resp_valid = 1'b0;
    end
  end

  // Output monitor / scoreboard.
  logic        ov_prev = 1'b0;
  logic        acc_prev = 1'b0;
  logic [15:0] y_prev = '0;
  logic        err_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ov_prev  = 1'b0;
      acc_prev = 1'b0;
    end else begin
      if (dut_start) begin
        n_starts++;
        start_cyc = cyc;
      end
      if (out_valid && !ov_prev) rise_cyc = cyc;
      if (ov_prev && !acc_prev && out_valid) begin
        check("hold_y", out_y, y_prev);
        check("hold_err", out_err, err_prev);
      end
      if (out_valid && out_ready) begin
        check("sb_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_cur = exp_q.pop_front();
          check("out_y", out_y, exp_cur.y);
          check("out_err", out_err, exp_cur.err);
          $display("result #%0d: y=%04h err=%0b (expected y=%04h err=%0b)",
                   n_pops, out_y, out_err, exp_cur.y, exp_cur.err);
        end
        n_pops++;
      end
      ov_prev  = out_valid;
      acc_prev = out_valid && out_ready;
      y_prev   = out_y;
      err_prev = out_err;
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic err, input logic [15:0] y);
    int   g = 0;
    logic rdy;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    push_cyc  = cyc;
    push_wait = 0;
    exp_q.push_back(exp_t'({err, y}));
    do begin
      rdy = in_ready;
      step();
      if (!rdy) push_wait++;
      g++;
    end while (!rdy && g < 500);
    in_valid = 1'b0;
    check("push_accept", rdy, 1);
  endtask

  task automatic wait_pops(input int target);
    int g = 0;
    while (n_pops < target && g < 500) begin
      step();
      g++;
    end
    check("drain", n_pops, target);
  endtask

  initial begin
    int s0;
    int g;
    int p0;
    logic [15:0] a, b;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_dut_start", dut_start, 0);
    check("rst_dut_a", dut_a, 0);
    check("rst_dut_b", dut_b, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
`ifdef DESIGN_08_ISSUER_STATS_EN
    check("rst_stat_done", stat_done, 0);
    check("rst_stat_tmo", stat_tmo, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Single op: 3 + 5, result two cycles after start.
    resp_en = 1'b1; resp_delay = 2;
    push(16'h0003, 16'h0005, 1'b0, 16'h0008);
    wait_pops(1);
    check("t2_starts", n_starts, 1);
    check("t2_issue_lat", start_cyc - push_cyc, 2);
    check("t2_done_lat", rise_cyc - start_cyc, 3);

    // Fill the FIFO behind a long-running op; the overflow push is held.
    resp_delay = 6;
    for (int i = 0; i < 6; i++) begin
      a = 16'h1000 + 16'(i);
      b = 16'h0010 * 16'(i + 1);
      push(a, b, 1'b0, a + b);
      if (i == 4) begin
        check("t3_full_in_ready", in_ready, 0);
        check("t3_full_busy", busy, 1);
      end
      if (i == 5) check("t3_held", 32'(push_wait > 3), 1);
    end
    wait_pops(7);

    // Timeout: no response ever; 15 WAIT cycles then out_valid.
    resp_en = 1'b0;
    push(16'h1234, 16'h0001, 1'b1, 16'h0000);
    wait_pops(8);
    check("t4_tmo_lat", rise_cyc - start_cyc, 16);
`ifdef DESIGN_08_ISSUER_STATS_EN
    check("t4_stat_tmo", stat_tmo, 1);
    check("t4_stat_done", stat_done, 7);
`endif

    // Backpressure: result held, stray dut_valid ignored, no new start.
    resp_en = 1'b1; resp_delay = 2; out_ready = 1'b0;
    s0 = n_starts;
    push(16'h0100, 16'h0023, 1'b0, 16'h0123);
    push(16'h0200, 16'h0045, 1'b0, 16'h0245);
    g = 0;
    while (!out_valid && g < 100) begin step(); g++; end
    check("t5_out_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 6) begin
        junk_valid = 1'b1; junk_y = 16'hDEAD;
      end else begin
        junk_valid = 1'b0;
      end
      step();
    end
    junk_valid = 1'b0;
    check("t5_no_new_start", n_starts - s0, 1);
    check("t5_still_valid", out_valid, 1);
    check("t5_held_y", out_y, 16'h0123);
    out_ready = 1'b1;
    wait_pops(10);
    check("t5_next_issued", n_starts - s0, 2);

    // Reset during WAIT aborts the transaction without output.
    resp_en = 1'b0;
    s0 = n_starts;
    push(16'h00AA, 16'h0055, 1'b1, 16'h0000);
    g = 0;
    while (n_starts == s0 && g < 50) begin step(); g++; end
    check("t6_started", n_starts - s0, 1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_dut_a", dut_a, 0);
    @(posedge clk); #1;
    p0 = n_pops;
    repeat (20) step();
    check("t6_no_output", n_pops, p0);
    resp_en = 1'b1;
    push(16'h0007, 16'h0009, 1'b0, 16'h0010);
    wait_pops(p0 + 1);
    check("t6_issue_lat", start_cyc - push_cyc, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
